quad_cmd_cfg: RTL and testbench

- Command front end of the quadcopter flight controller.
- Receives 3-byte host packets over an 8N1 UART and decodes them.
- Holds the flight setpoints (pitch, roll, yaw, thrust), sequences calibration and motor-off, and returns a 0xA5 acknowledge byte.
- Sits between the RX/TX pins and the flight-control / inertial-integration blocks.

---
 rtl/quad_pkg.sv | 12 +
 rtl/quad_uart.sv | 89 ++++++++
 rtl/quad_cmd_cfg.sv | 126 ++++++++++++
 tb/tb_quad_cmd_cfg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: command encodings, acknowledge byte and FSM states of the quadcopter command front end
package quad_pkg;
  localparam logic [7:0] CMD_PTCH  = 8'h02;
  localparam logic [7:0] CMD_ROLL  = 8'h03;
  localparam logic [7:0] CMD_YAW   = 8'h04;
  localparam logic [7:0] CMD_THRST = 8'h05;
  localparam logic [7:0] CMD_CAL   = 8'h06;
  localparam logic [7:0] CMD_EMER  = 8'h07;
  localparam logic [7:0] CMD_MOFF  = 8'h08;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT_CAL, ST_ACK} state_e;
endpackage

// File: rtl/quad_uart.sv
// quad_uart: full-duplex 8N1 transceiver, LSB first, BAUD_DIV clocks per bit
// RX/TX: serial pins (idle high); rx_data/rx_rdy: received byte, rx_rdy held until clr_rx_rdy;
// tx_data/trmt: byte to send, taken when the transmitter is idle; tx_done: one-cycle end-of-frame pulse
module quad_uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  logic rx1_q, rx2_q, rxb_q, rx_rdy_q, txb_q, tx_done_q;
  logic [CW-1:0] rxc_q, txc_q;
  logic [3:0] rxn_q, txn_q;
  logic [7:0] rxs_q;
  logic [9:0] txs_q;
  // rxn_q: 0 = start bit, 1..8 = data, 9 = stop; a start bit high at mid-bit is a glitch
  always_ff @(posedge clk)
    if (rst) begin
      rx1_q <= 1'b1;
      rx2_q <= 1'b1;
      rxb_q <= 1'b0;
      rx_rdy_q <= 1'b0;
      rxc_q <= '0;
      rxn_q <= '0;
      rxs_q <= '0;
    end else begin
      rx1_q <= RX;
      rx2_q <= rx1_q;
      if (clr_rx_rdy) rx_rdy_q <= 1'b0;
      if (!rxb_q) begin
        if (!rx2_q) begin
          rxb_q <= 1'b1;
          rxc_q <= HALF;
          rxn_q <= '0;
        end
      end else if (rxc_q != '0) rxc_q <= rxc_q - 1'b1;
      else begin
        rxc_q <= FULL;
        rxn_q <= rxn_q + 1'b1;
        if (rxn_q == 4'd0 && rx2_q) rxb_q <= 1'b0;
        else if (rxn_q == 4'd9) begin
          rxb_q <= 1'b0;
          rx_rdy_q <= 1'b1;
        end else if (rxn_q != 4'd0) rxs_q <= {rx2_q, rxs_q[7:1]};
      end
    end
  // txs_q[0] is the line itself; ones shift in behind the frame so it idles high
  always_ff @(posedge clk)
    if (rst) begin
      txb_q <= 1'b0;
      tx_done_q <= 1'b0;
      txc_q <= '0;
      txn_q <= '0;
      txs_q <= '1;
    end else begin
      tx_done_q <= 1'b0;
      if (!txb_q) begin
        if (trmt) begin
          txb_q <= 1'b1;
          txs_q <= {1'b1, tx_data, 1'b0};
          txc_q <= FULL;
          txn_q <= '0;
        end
      end else if (txc_q != '0) txc_q <= txc_q - 1'b1;
      else begin
        txc_q <= FULL;
        txs_q <= {1'b1, txs_q[9:1]};
        txn_q <= txn_q + 1'b1;
        if (txn_q == 4'd9) begin
          txb_q <= 1'b0;
          tx_done_q <= 1'b1;
        end
      end
    end
  assign TX = txs_q[0];
  assign rx_data = rxs_q;
  assign rx_rdy = rx_rdy_q;
  assign tx_done = tx_done_q;
endmodule

// File: rtl/quad_cmd_cfg.sv
// quad_cmd_cfg: UART command front end holding flight setpoints, calibration/motor-off sequencing and ACK reply
// RX/TX: host serial link; cal_done/strt_cal/inertial_cal: calibration handshake with the inertial block;
// d_ptch/d_roll/d_yaw/thrst: setpoints; motors_off: forces ESCs idle
module quad_cmd_cfg import quad_pkg::*; #(
  parameter int         BAUD_DIV = 2604,
  parameter bit         FAST_SIM = 1'b0,
  parameter logic [7:0] ACK      = ACK_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic        inertial_cal,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        motors_off
);
  localparam int WDW = FAST_SIM ? 9 : 26;
  localparam logic [WDW-1:0] WD_PRE = ~WDW'(1);
  state_e state_q, state_d;
  logic [7:0] rx_data, b0_q, b1_q, pc_q, cc_q;
  logic [15:0] pd_q, cd_q, ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
  logic [8:0] thrst_q, thrst_d;
  logic [1:0] bc_q;
  logic [16:0] gap_q;
  logic [WDW-1:0] wd_q, wd_d;
  logic rx_rdy, tx_done, trmt, cmd_rdy_q, pv_q, pv_d, txb_q, txb_d, take, ex, emer, wd_fire;
  logic moff_q, moff_d, strt_q, strt_d, ical_q, ical_d;
  quad_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(rx_rdy),
    .tx_data(ACK), .trmt(trmt), .tx_done(tx_done)
  );
  always_comb begin
    state_d = state_q;
    trmt = 1'b0;
    case (state_q)
      ST_IDLE: if (take) state_d = ST_EXEC;
      ST_EXEC: state_d = cc_q == CMD_CAL ? ST_WAIT_CAL : ST_ACK;
      ST_WAIT_CAL: if (cal_done) state_d = ST_ACK;
      default: begin
        trmt = !txb_q;
        if (!txb_q) state_d = ST_IDLE;
      end
    endcase
  end
  // a packet completing outside IDLE waits in pc_q/pd_q with pv_q set until the FSM returns to IDLE
  always_comb begin
    take = cmd_rdy_q || pv_q;
    ex = state_q == ST_EXEC;
    wd_fire = !cmd_rdy_q && wd_q == WD_PRE;
    emer = wd_fire || (ex && cc_q == CMD_EMER);
    ptch_d = emer ? '0 : (ex && cc_q == CMD_PTCH) ? cd_q : ptch_q;
    roll_d = emer ? '0 : (ex && cc_q == CMD_ROLL) ? cd_q : roll_q;
    yaw_d = emer ? '0 : (ex && cc_q == CMD_YAW) ? cd_q : yaw_q;
    thrst_d = emer ? '0 : (ex && cc_q == CMD_THRST) ? cd_q[8:0] : thrst_q;
    strt_d = ex && cc_q == CMD_CAL;
    moff_d = strt_d ? 1'b0 : (ex && cc_q == CMD_MOFF) ? 1'b1 : moff_q;
    ical_d = strt_d || (ical_q && !(state_q == ST_WAIT_CAL && cal_done));
    pv_d = state_q != ST_IDLE && (cmd_rdy_q || pv_q);
    txb_d = trmt || (txb_q && !tx_done);
    wd_d = cmd_rdy_q ? '0 : (&wd_q) ? wd_q : wd_q + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      bc_q <= '0;
      gap_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      pc_q <= '0;
      pd_q <= '0;
      cc_q <= '0;
      cd_q <= '0;
      cmd_rdy_q <= 1'b0;
      pv_q <= 1'b0;
      txb_q <= 1'b0;
      wd_q <= '0;
      ptch_q <= '0;
      roll_q <= '0;
      yaw_q <= '0;
      thrst_q <= '0;
      moff_q <= 1'b1;
      strt_q <= 1'b0;
      ical_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q <= pv_d;
      txb_q <= txb_d;
      wd_q <= wd_d;
      ptch_q <= ptch_d;
      roll_q <= roll_d;
      yaw_q <= yaw_d;
      thrst_q <= thrst_d;
      moff_q <= moff_d;
      strt_q <= strt_d;
      ical_q <= ical_d;
      cmd_rdy_q <= rx_rdy && bc_q == 2'd2;
      if (state_q == ST_IDLE && take) begin
        cc_q <= pc_q;
        cd_q <= pd_q;
      end
      if (rx_rdy) begin
        bc_q <= bc_q == 2'd2 ? 2'd0 : bc_q + 1'b1;
        gap_q <= '0;
        if (bc_q == 2'd0) b0_q <= rx_data;
        if (bc_q == 2'd1) b1_q <= rx_data;
        if (bc_q == 2'd2) begin
          pc_q <= b0_q;
          pd_q <= {b1_q, rx_data};
        end
      end else if (gap_q[16]) bc_q <= '0;
      else if (bc_q != '0) gap_q <= gap_q + 1'b1;
    end
  assign strt_cal = strt_q;
  assign inertial_cal = ical_q;
  assign d_ptch = ptch_q;
  assign d_roll = roll_q;
  assign d_yaw = yaw_q;
  assign thrst = thrst_q;
  assign motors_off = moff_q;
endmodule

// File: tb/tb_quad_cmd_cfg.sv
// tb_quad_cmd_cfg: randomized directed-sequence bench with a behavioural setpoint model for quad_cmd_cfg
module tb_quad_cmd_cfg;
  localparam int BD = 8;
  localparam logic [7:0] ACKB = 8'hA5;
  logic clk = 1'b0, rst = 1'b1, RX = 1'b1, cal_done = 1'b0;
  logic TX, strt_cal, inertial_cal, motors_off, s_prev;
  logic [15:0] d_ptch, d_roll, d_yaw, e_ptch, e_roll, e_yaw;
  logic [8:0] thrst, e_thr;
  logic e_moff;
  int checks = 0, errors = 0, s_cnt = 0, s_dbl = 0, tx_starts = 0;
  logic [7:0] rxq[$];
  logic [7:0] cmds [11] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h01, 8'h09, 8'hFF};
  quad_cmd_cfg #(.BAUD_DIV(BD), .FAST_SIM(1'b1), .ACK(ACKB)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cal_done(cal_done),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst), .motors_off(motors_off)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    s_prev <= strt_cal;
    if (strt_cal) s_cnt <= s_cnt + 1;
    if (strt_cal && s_prev) s_dbl <= s_dbl + 1;
  end
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (TX === 1'b0 && rst === 1'b0) begin
      tx_starts++;
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = TX;
      end
      repeat (BD) @(negedge clk);
      rxq.push_back(b);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = 1'b1;
    tick(BD);
  endtask
  task automatic send_pkt(input logic [7:0] c, input logic [15:0] d);
    send_byte(c);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask
  task automatic model(input logic [7:0] c, input logic [15:0] d);
    if (c == 8'h02) e_ptch = d;
    else if (c == 8'h03) e_roll = d;
    else if (c == 8'h04) e_yaw = d;
    else if (c == 8'h05) e_thr = d[8:0];
    else if (c == 8'h06) e_moff = 1'b0;
    else if (c == 8'h07) begin
      e_ptch = '0;
      e_roll = '0;
      e_yaw = '0;
      e_thr = '0;
    end else if (c == 8'h08) e_moff = 1'b1;
  endtask
  task automatic wait_ack(input string tag);
    int n = 0;
    while (rxq.size() == 0 && n < 600) begin
      tick(1);
      n++;
    end
    chk({tag, "_ack_seen"}, 32'(rxq.size() != 0), 1);
    if (rxq.size() != 0) chk({tag, "_ack"}, 32'(rxq.pop_front()), 32'(ACKB));
  endtask
  task automatic wait_strt(input string tag, input int s0);
    int n = 0;
    while (s_cnt == s0 && n < 200) begin
      tick(1);
      n++;
    end
    chk({tag, "_strt_once"}, s_cnt, s0 + 1);
  endtask
  task automatic chk_state(input string tag);
    chk({tag, "_ptch"}, 32'(d_ptch), 32'(e_ptch));
    chk({tag, "_roll"}, 32'(d_roll), 32'(e_roll));
    chk({tag, "_yaw"}, 32'(d_yaw), 32'(e_yaw));
    chk({tag, "_thrst"}, 32'(thrst), 32'(e_thr));
    chk({tag, "_moff"}, 32'(motors_off), 32'(e_moff));
    chk({tag, "_ical"}, 32'(inertial_cal), 0);
    chk({tag, "_strt"}, 32'(strt_cal), 0);
  endtask
  task automatic cal_wait(input string tag, input int dly, input int t0);
    int bad = 0;
    for (int i = 0; i < dly; i++) begin
      if (inertial_cal !== 1'b1) bad++;
      tick(1);
    end
    chk({tag, "_ical_hold"}, bad, 0);
    chk({tag, "_no_early_ack"}, tx_starts, t0);
    cal_done = 1'b1;
    tick(1);
    cal_done = 1'b0;
  endtask
  task automatic do_pkt(input string tag, input logic [7:0] c, input logic [15:0] d, input int dly);
    int s0, t0;
    s0 = s_cnt;
    t0 = tx_starts;
    send_pkt(c, d);
    model(c, d);
    if (c == 8'h06) begin
      wait_strt(tag, s0);
      cal_wait(tag, dly, t0);
    end
    wait_ack(tag);
    chk_state(tag);
  endtask
  initial begin
    logic [15:0] d;
    int s0, t0, n;
    e_ptch = '0;
    e_roll = '0;
    e_yaw = '0;
    e_thr = '0;
    e_moff = 1'b1;
    tick(5);
    chk("reset_tx", 32'(TX), 1);
    chk_state("reset");
    rst = 1'b0;
    tick(5);
    do_pkt("cal0", 8'h06, 16'h0000, 100);
    do_pkt("thr", 8'h05, 16'h00FF, 0);
    chk("thr_val", 32'(thrst), 32'h0FF);
    do_pkt("ptch", 8'h02, 16'h0100, 0);
    do_pkt("roll", 8'h03, 16'hFF80, 0);
    do_pkt("yaw", 8'h04, 16'h0080, 0);
    do_pkt("emer", 8'h07, 16'h0000, 0);
    do_pkt("moff", 8'h08, 16'h0000, 0);
    do_pkt("cal1", 8'h06, 16'h0000, 40);
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom);
      do_pkt($sformatf("rnd%0d", i), cmds[$urandom_range(0, 10)], d, int'($urandom_range(10, 90)));
    end
    s0 = s_cnt;
    t0 = tx_starts;
    send_pkt(8'h06, 16'h0000);
    model(8'h06, 16'h0000);
    wait_strt("buf", s0);
    send_pkt(8'h05, 16'h01A5);
    model(8'h05, 16'h01A5);
    cal_wait("buf", 20, t0);
    wait_ack("buf1");
    wait_ack("buf2");
    chk_state("buf");
    do_pkt("wd_p", 8'h02, 16'h1111, 0);
    do_pkt("wd_t", 8'h05, 16'h00FF, 0);
    t0 = tx_starts;
    tick(600);
    e_ptch = '0;
    e_roll = '0;
    e_yaw = '0;
    e_thr = '0;
    chk_state("wd");
    chk("wd_no_tx", tx_starts, t0);
    RX = 1'b0;
    tick(BD / 2 - 1);
    RX = 1'b1;
    tick(50);
    chk("glitch_no_tx", tx_starts, t0);
    do_pkt("glitch", 8'h05, 16'h0123, 0);
    t0 = tx_starts;
    send_pkt(8'h02, 16'h1234);
    n = 0;
    while (tx_starts == t0 && n < 200) begin
      tick(1);
      n++;
    end
    chk("rst_tx_started", tx_starts, t0 + 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_tx_high", 32'(TX), 1);
    tick(2);
    rst = 1'b0;
    e_ptch = '0;
    e_roll = '0;
    e_yaw = '0;
    e_thr = '0;
    e_moff = 1'b1;
    tick(100);
    rxq.delete();
    chk_state("rst_mid");
    chk("strt_single_cycle", s_dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
